// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: measures baud from a 0x55 sync byte, sequences receiver reset/verify, and buffers bytes in a 4-entry FIFO.
module uart_autobaud_ctrl #(
  parameter logic [19:0] DEFAULT_CYCLE = 20'd433,
  parameter logic [19:0] MIN_CYCLE     = 20'd7,
  parameter logic [19:0] MAX_CYCLE     = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  output logic        rx_rst_n,
  output logic [19:0] cycle,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        relock,
  output logic        locked,
  output logic        err
);
  typedef enum logic [2:0] {HUNT, MEASURE, SETTLE, VERIFY, LOCKED} state_t;
  localparam logic [23:0] TMO = {1'b0, MAX_CYCLE, 3'b000} + 24'd8;
  state_t      state, state_n;
  logic        rx_meta, rxs, rxs_d, fe;
  logic [23:0] cnt, cnt_n;
  logic [1:0]  fe_cnt, fe_n;
  logic [19:0] cycle_n;
  logic        err_n, c_ok, push, pop;
  logic [21:0] c;
  logic [7:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  occ;
  assign fe = rxs_d & ~rxs;
  // eight measured periods, rounded, divided by eight, minus one
  assign c = 22'(({1'b0, cnt} + 25'd5) >> 3) - 22'd1;
  assign c_ok = c >= {2'b0, MIN_CYCLE} && c <= {2'b0, MAX_CYCLE};
  assign rx_data_ready = (state == VERIFY) | (state == LOCKED & ~occ[2]);
  assign push = state == LOCKED && state_n == LOCKED && rx_data_valid && rx_data_ready;
  assign pop = out_valid && out_ready;
  assign out_valid = occ != 3'd0;
  assign out_data = mem[rp];
  always_comb begin
    state_n = state;
    cnt_n = cnt + 24'd1;
    fe_n = fe_cnt;
    cycle_n = cycle;
    err_n = 1'b0;
    case (state)
      HUNT: if (fe) begin
        state_n = MEASURE;
        cnt_n = '0;
        fe_n = '0;
      end
      MEASURE: if (fe && fe_cnt == 2'd3) begin
        state_n = c_ok ? SETTLE : HUNT;
        err_n = !c_ok;
        cycle_n = c_ok ? c[19:0] : cycle;
        cnt_n = '0;
      end else if (cnt == TMO) begin
        state_n = HUNT;
        err_n = 1'b1;
      end else fe_n = fe_cnt + {1'b0, fe};
      // cnt holds the run length so far; this clock completes the run
      SETTLE: if (!rxs) cnt_n = '0;
        else if (cnt == {3'b0, cycle, 1'b1}) state_n = VERIFY;
      VERIFY: if (rx_data_valid) begin
        state_n = rx_data == 8'h55 ? LOCKED : HUNT;
        err_n = rx_data != 8'h55;
        cnt_n = '0;
      end
      LOCKED: if (rxs) cnt_n = '0;
        else if (cnt == {cycle, 4'hF}) state_n = HUNT;
      default: state_n = HUNT;
    endcase
    if (relock) begin
      state_n = HUNT;
      err_n = 1'b0;
      cycle_n = cycle;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_meta, rxs, rxs_d} <= 3'b111;
      state <= HUNT;
      cnt <= '0;
      fe_cnt <= '0;
      cycle <= DEFAULT_CYCLE;
      err <= 1'b0;
      locked <= 1'b0;
      rx_rst_n <= 1'b0;
    end else begin
      {rxs_d, rxs, rx_meta} <= {rxs, rx_meta, rx_pin};
      state <= state_n;
      cnt <= cnt_n;
      fe_cnt <= fe_n;
      cycle <= cycle_n;
      err <= err_n;
      locked <= state_n == LOCKED;
      rx_rst_n <= state == VERIFY || state == LOCKED;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else if (state_n != LOCKED) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        mem[wp] <= rx_data;
        wp <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      occ <= occ + {2'b0, push} - {2'b0, pop};
    end
endmodule

// File: doc/uart_autobaud_ctrl.md
# uart_autobaud_ctrl

Sequencing and configuration controller for the serial byte receiver. It measures the host's baud rate from a 0x55 sync character and drives the receiver's 20-bit `cycle` configuration. It holds the receiver in reset until the rate is known, then verifies lock with a second 0x55 and feeds received bytes through a 4-entry FIFO to the downstream valid/ready consumer. It sits between the board serial pin and the command parser.

## Interface
- `DEFAULT_CYCLE`, 433: `cycle` value driven from reset until the first successful measurement.
- `MIN_CYCLE`, 7: smallest acceptable measured `cycle`. Anything lower aborts the measurement.
- `MAX_CYCLE`, 20'hFFFFF: largest acceptable `cycle`. Sets the measurement timeout.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_pin` in 1: raw serial line, idle high. The receiver gets the same pin.
- `rx_rst_n` out 1: active-low reset for the receiver, registered.
- `cycle` out 20: bit period minus 1, in clocks, to the receiver.
- `rx_data` in 8: byte from the receiver.
- `rx_data_valid` in 1: receiver byte valid, high for exactly one cycle when ready is high.
- `rx_data_ready` out 1: accept strobe to the receiver.
- `out_data` out 8: FIFO head byte.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: downstream pop.
- `relock` in 1: one-cycle request to re-measure.
- `locked` out 1: baud rate verified.
- `err` out 1: one-cycle pulse on measurement or verify failure.

## Operation
- `rx_pin` passes through a 2-flop synchronizer (`rxs`). All edge and level detection in this block uses `rxs`.
- States: HUNT, MEASURE, SETTLE, VERIFY, LOCKED.
- **HUNT**
  - `rx_rst_n`=0, `locked`=0.
  - On a falling edge of `rxs`: clear `cnt`, clear `fe_cnt`, go to MEASURE.
- **MEASURE**
  - `cnt` is 24 bits and increments every clock.
  - Each falling edge of `rxs` increments `fe_cnt`.
  - A 0x55 frame has falling edges at bit positions 0, 2, 4, 6 and 8. On the 4th falling edge counted after the start edge, `cnt` spans 8 bit periods.
  - At that edge compute `c = ((cnt+1+4)>>3) - 1`. That is 8 periods rounded, divided by 8, minus 1.
  - If `MIN_CYCLE ≤ c ≤ MAX_CYCLE`: register `cycle <= c`, go to SETTLE.
  - Otherwise: pulse `err`, go to HUNT.
  - If `cnt` reaches `8*(MAX_CYCLE+1)` first: pulse `err`, go to HUNT.
- **SETTLE**
  - `rx_rst_n` stays 0.
  - Count consecutive clocks with `rxs`=1. Any low level clears the count.
  - When the count reaches `2*(cycle+1)`: set `rx_rst_n` to 1, go to VERIFY.
- **VERIFY**
  - `rx_data_ready`=1.
  - First accepted byte == 0x55: set `locked`=1, go to LOCKED. The byte is discarded.
  - Any other value: pulse `err`, go to HUNT.
- **LOCKED**
  - `rx_data_ready` = FIFO not full.
  - A byte is accepted when `rx_data_valid && rx_data_ready` and is pushed to the FIFO.
  - Break detection: if `rxs` stays low continuously for `16*(cycle+1)` clocks, clear `locked`, flush the FIFO, go to HUNT.
- `relock` in any state: flush the FIFO, clear `locked`, go to HUNT. `cycle` keeps its value.
- Outside LOCKED the FIFO is empty and `rx_data_ready` is 1, except in HUNT, MEASURE and SETTLE, where it is 0.
- FIFO behaviour:
  - 4 entries, 2-bit pointers that wrap, 3-bit occupancy.
  - Push and pop in the same cycle when full: the pop frees a slot, but `rx_data_ready` is computed from registered occupancy. The push is therefore not accepted that cycle and waits for the receiver to re-present the byte.
  - The receiver holds valid until it sees ready, so no byte is lost.

## Timing
- Reset values:
  - `rx_rst_n`=0, `cycle`=DEFAULT_CYCLE, `rx_data_ready`=0.
  - `out_valid`=0, `out_data`=0, `locked`=0, `err`=0.
  - State HUNT, FIFO empty.
- `rx_rst_n` changes 1 clock after the SETTLE exit condition. It drops 1 clock after the edge that enters HUNT.
- `cycle` updates on the clock edge that leaves MEASURE. It is stable while `rx_rst_n`=1.
- `locked` rises 1 clock after the accepted 0x55 in VERIFY.
- `err` is high exactly 1 clock.
- FIFO latency: a byte accepted at edge N drives `out_valid`=1 after edge N when the FIFO was empty.
- `out_data` is the head entry and is valid whenever `out_valid`=1.
- Pop happens on `out_valid && out_ready`.
- Reset asserted mid-frame returns everything to reset values immediately.

## Test plan
- **Lock at 434 clocks per bit (50 MHz, 115200 baud):**
  - Stimulus: send 0x55, idle 3 bit periods, send 0x55.
  - Required: `cycle`=433, `rx_rst_n` rises during idle, `locked`=1, no bytes on `out_valid`.
- **Jitter rounding:**
  - Stimulus: bit period 100 with one edge skewed by +3 clocks.
  - Required: `cycle`=99.
- **Verify failure:**
  - Stimulus: 0x55 then 0x41.
  - Required: single `err` pulse, `locked`=0, `rx_rst_n`=0, state returns to HUNT.
- **Out-of-range measurement:**
  - Stimulus: 0x55 at 4 clocks per bit.
  - Required: `err` pulse, `cycle` unchanged.
  - Stimulus: line held low after one falling edge.
  - Required: timeout `err`.
- **FIFO full and backpressure:**
  - Stimulus: locked, `out_ready`=0, send 6 bytes 0x01..0x06 back-to-back.
  - Required: `rx_data_ready`=0 after 4 bytes are stored.
  - Stimulus: release `out_ready`.
  - Required: 0x01..0x04 emerge in order. 0x05 is delivered once the receiver re-presents it. Bytes arriving while full are not duplicated.
- **Break and relock:**
  - Stimulus: locked, hold line low for 16 bit periods.
  - Required: `locked` falls, FIFO flushed, HUNT.
  - Stimulus: pulse `relock` while in VERIFY.
  - Required: HUNT next cycle with `cycle` retained.
